// File: rtl/load_unit_pkg.sv
// Shared definitions for the load unit: funct3 load-width codes, FSM state
// encoding and the alignment rule used when a load is accepted.
package load_unit_pkg;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Undefined funct3 codes fall into the word rule.
    function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] off);
        case (sel)
            LOAD_LB, LOAD_LBU: is_misaligned = 1'b0;
            LOAD_LH, LOAD_LHU: is_misaligned = off[0];
            default:           is_misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_unit_extender.sv
// Combinational lane select and sign/zero extension of a little-endian bus word.
module load_unit_extender
    import load_unit_pkg::*;
(
    input  logic [2:0]  sel_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = word_i[{off_i, 3'b000} +: 8];
    assign half_s = word_i[{off_i[1], 4'b0000} +: 16];

    // Extend the selected lane to 32 bits.
    always_comb begin
        data_o = word_i;
        case (sel_i)
            LOAD_LB:  data_o = {{24{byte_s[7]}}, byte_s};
            LOAD_LH:  data_o = {{16{half_s[15]}}, half_s};
            LOAD_LBU: data_o = {24'h000000, byte_s};
            LOAD_LHU: data_o = {16'h0000, half_s};
            default:  data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Data-memory load path: req/ack word read with timeout, then byte/half/word
// extraction and extension, returned with a one-cycle done pulse.
module load_unit
    import load_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_start,
    input  logic [2:0]  I_loadsel,
    input  logic [31:0] I_addr,
    output logic        O_busy,
    output logic        O_done,
    output logic [31:0] O_data,
    output logic        O_misaligned,
    output logic        O_fault,
    output logic        O_mem_req,
    output logic [31:0] O_mem_addr,
    input  logic        I_mem_ack,
    input  logic [31:0] I_mem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         sel_q, sel_d;
    logic [1:0]         off_q, off_d;
    logic [31:0]        addr_q, addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        data_q, data_d;
    logic               mis_q, mis_d;
    logic               fault_q, fault_d;
    logic               req_q, req_d;

    logic [31:0]        ext_data_s;
    logic               mis_start_s;
    logic               timeout_s;

    assign mis_start_s = is_misaligned(I_loadsel, I_addr[1:0]);
    assign timeout_s   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    load_unit_extender u_ext (
        .sel_i  (sel_q),
        .off_i  (off_q),
        .word_i (I_mem_rdata),
        .data_o (ext_data_s)
    );

    // State register.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an ack in the timeout cycle still counts as success.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (I_start) begin
                    state_d = mis_start_s ? ST_DONE : ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (I_mem_ack || timeout_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values; results and flags hold between loads.
    always_comb begin
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        off_d   = off_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        data_d  = data_q;
        mis_d   = mis_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (I_start) begin
                    sel_d   = I_loadsel;
                    off_d   = I_addr[1:0];
                    addr_d  = {I_addr[31:2], 2'b00};
                    cnt_d   = {CNT_W{1'b0}};
                    fault_d = 1'b0;
                    mis_d   = mis_start_s;
                    if (mis_start_s) begin
                        done_d = 1'b1;
                        data_d = 32'h0000_0000;
                    end else begin
                        done_d = 1'b0;
                    end
                end else begin
                    done_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (I_mem_ack) begin
                    done_d = 1'b1;
                    data_d = ext_data_s;
                end else if (timeout_s) begin
                    done_d  = 1'b1;
                    data_d  = 32'h0000_0000;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
        req_d  = (state_d == ST_REQ);
        busy_d = (state_d != ST_IDLE);
    end

    // Output and latched-request registers.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            cnt_q   <= {CNT_W{1'b0}};
            sel_q   <= 3'b000;
            off_q   <= 2'b00;
            addr_q  <= 32'h0000_0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= 32'h0000_0000;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            data_q  <= data_d;
            mis_q   <= mis_d;
            fault_q <= fault_d;
            req_q   <= req_d;
        end
    end

    assign O_busy       = busy_q;
    assign O_done       = done_q;
    assign O_data       = data_q;
    assign O_misaligned = mis_q;
    assign O_fault      = fault_q;
    assign O_mem_req    = req_q;
    assign O_mem_addr   = addr_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: stimulus pushes expected results into a queue,
// an independent monitor pops and compares on every O_done.
module tb_load_unit;

    localparam int TO = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        mis;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  loadsel = 3'b000;
    logic [31:0] addr_in = 32'h0;
    logic        ack = 1'b0;
    logic [31:0] rdata_in = 32'h0;
    logic        busy, done, mis, fault, req;
    logic [31:0] data, mem_addr;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    load_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .I_clk        (clk),
        .I_rst        (rst),
        .I_start      (start),
        .I_loadsel    (loadsel),
        .I_addr       (addr_in),
        .O_busy       (busy),
        .O_done       (done),
        .O_data       (data),
        .O_misaligned (mis),
        .O_fault      (fault),
        .O_mem_req    (req),
        .O_mem_addr   (mem_addr),
        .I_mem_ack    (ack),
        .I_mem_rdata  (rdata_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got O_done=1 expected no pending load");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_data", data, e.data);
                chk("sb_misaligned", {31'b0, mis}, {31'b0, e.mis});
                chk("sb_fault", {31'b0, fault}, {31'b0, e.fault});
            end
        end
    end

    task automatic do_load(input string name, input logic [2:0] sel, input logic [31:0] addr,
                           input int waits, input bit no_ack, input logic [31:0] rdata,
                           input logic [31:0] exp_data, input bit exp_mis, input bit exp_fault,
                           input bit extra_start);
        int n;
        exp_q.push_back(exp_t'({exp_data, exp_mis, exp_fault}));
        start = 1'b1; loadsel = sel; addr_in = addr;
        @(posedge clk); #1;
        start = 1'b0; loadsel = 3'b111; addr_in = 32'hFFFF_FFFF;
        chk({name, "_fault_clear"}, {31'b0, fault}, 32'h0);
        chk({name, "_mis_flag"}, {31'b0, mis}, {31'b0, exp_mis});
        if (exp_mis) begin
            chk({name, "_no_req"}, {31'b0, req}, 32'h0);
            chk({name, "_done"}, {31'b0, done}, 32'h1);
        end else begin
            n = no_ack ? TO : waits;
            for (int i = 0; i < n; i++) begin
                chk({name, "_req_wait"}, {31'b0, req}, 32'h1);
                chk({name, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
                if (extra_start && i == 0) begin
                    start = 1'b1; loadsel = 3'b000; addr_in = 32'h0000_0400;
                end
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (!no_ack) begin
                chk({name, "_req_ack"}, {31'b0, req}, 32'h1);
                chk({name, "_mem_addr_ack"}, mem_addr, {addr[31:2], 2'b00});
                ack = 1'b1; rdata_in = rdata;
                @(posedge clk); #1;
                ack = 1'b0; rdata_in = 32'h5A5A_5A5A;
            end
            chk({name, "_req_drop"}, {31'b0, req}, 32'h0);
            chk({name, "_done"}, {31'b0, done}, 32'h1);
        end
        @(posedge clk); #1;
        chk({name, "_done_pulse"}, {31'b0, done}, 32'h0);
        chk({name, "_idle"}, {31'b0, busy}, 32'h0);
        chk({name, "_data_held"}, data, exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_data", data, 32'h0);
        chk("rst_req", {31'b0, req}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_flags", {30'b0, mis, fault}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_load("lb_off3",   3'b000, 32'h0000_0103, 0, 1'b0, 32'h8011_2233, 32'hFFFF_FF80, 1'b0, 1'b0, 1'b0);
        do_load("lhu_waits", 3'b101, 32'h0000_0102, 3, 1'b0, 32'h9ABC_1234, 32'h0000_9ABC, 1'b0, 1'b0, 1'b0);
        do_load("lw_mis",    3'b010, 32'h0000_0202, 0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0);
        do_load("lh_sext",   3'b001, 32'h0000_0000, 1, 1'b0, 32'h0000_8001, 32'hFFFF_8001, 1'b0, 1'b0, 1'b0);
        do_load("lbu_off1",  3'b100, 32'h0000_0001, 0, 1'b0, 32'h0000_F000, 32'h0000_00F0, 1'b0, 1'b0, 1'b0);
        do_load("lh_mis",    3'b001, 32'h0000_0101, 0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0);
        do_load("f011_mis",  3'b011, 32'h0000_0006, 0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0);
        do_load("f110_word", 3'b110, 32'h0000_0008, 0, 1'b0, 32'h8765_4321, 32'h8765_4321, 1'b0, 1'b0, 1'b0);
        do_load("timeout",   3'b010, 32'h0000_0010, 0, 1'b1, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0);
        do_load("after_to",  3'b010, 32'h0000_0004, 0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        do_load("busy_start",3'b010, 32'h0000_0020, 1, 1'b0, 32'h1122_3344, 32'h1122_3344, 1'b0, 1'b0, 1'b1);

        ack = 1'b1; rdata_in = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("stray_ack_busy", {31'b0, busy}, 32'h0);
            chk("stray_ack_req", {31'b0, req}, 32'h0);
        end
        ack = 1'b0;

        start = 1'b1; loadsel = 3'b010; addr_in = 32'h0000_0040;
        @(posedge clk); #1;
        start = 1'b0;
        chk("pre_rst_req", {31'b0, req}, 32'h1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_req", {31'b0, req}, 32'h0);
        chk("async_rst_busy", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_done", {31'b0, done}, 32'h0);

        do_load("lw_after_rst", 3'b010, 32'h0000_0300, 0, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
